// File: rtl/demux1_4_buf_if.sv
// Producer/consumer bundle for the buffered 1-to-4 demultiplexer.
// The master side drives the producer offer and the consumer ready lines; the slave side is the demux.
interface demux1_4_buf_if #(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0]      in_data;
    logic [1:0]            in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][WIDTH-1:0] out_data;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [3:0]            lane_full;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, lane_full
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, lane_full
    );
endinterface

// File: rtl/demux1_4_buf.sv
// Buffered 1-to-4 stream demux: one producer steers words into four
// independent 2-entry FIFO lanes, each drained by its own consumer.
module demux1_4_buf #(
    parameter int unsigned WIDTH = 64
) (
    input logic           clk,
    input logic           reset,
    demux1_4_buf_if.slave bus
);
    logic [WIDTH-1:0] mem [4][2];
    logic [3:0]       rd_ptr;
    logic [3:0]       wr_ptr;
    logic [1:0]       cnt [4];
    logic [3:0]       full;
    logic [3:0]       nonempty;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic             accept;

    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            full[k]     = (cnt[k] == 2'd2);
            nonempty[k] = (cnt[k] != 2'd0);
        end
    end

    // Readiness looks only at registered occupancy, so a full lane refuses
    // a push even when its consumer pops in the same cycle.
    assign accept = bus.in_valid & bus.in_ready;
    assign bus.in_ready  = ~reset & ~full[bus.in_sel];
    assign bus.out_valid = nonempty;
    assign bus.lane_full = full;

    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            push[k] = accept & (bus.in_sel == 2'(k));
            pop[k]  = nonempty[k] & bus.out_ready[k];
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            bus.out_data[k] = mem[k][rd_ptr[k]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                cnt[k]    <= '0;
                mem[k][0] <= '0;
                mem[k][1] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= bus.in_data;
                    wr_ptr[k]         <= ~wr_ptr[k];
                end
                if (pop[k]) begin
                    rd_ptr[k] <= ~rd_ptr[k];
                end
                case ({push[k], pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + 2'd1;
                    2'b01:   cnt[k] <= cnt[k] - 2'd1;
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_demux1_4_buf.sv
// Directed and randomized checks of the buffered 1-to-4 demultiplexer.
// Inputs change and outputs are sampled 1 ns after the falling clock edge.
module tb_demux1_4_buf;
    localparam int unsigned WIDTH = 64;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    demux1_4_buf_if #(.WIDTH(WIDTH)) bus ();

    demux1_4_buf #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [3:0] r);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, 2'd0, 64'hFF, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            tests++;
            if (bus.in_ready !== 1'b0) begin
                fails++; $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready);
            end
            tests++;
            if (bus.out_valid !== 4'b0000 || bus.lane_full !== 4'b0000) begin
                fails++; $display("FAIL reset_flags: got valid=%b full=%b exp 0000/0000",
                                  bus.out_valid, bus.lane_full);
            end
            tests++;
            if (bus.out_data !== '0) begin
                fails++; $display("FAIL reset_data: got %h exp 0", bus.out_data);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 2'd0, '0, 4'b0000);
        #1;
        tests++;
        if (bus.out_valid !== 4'b0000) begin
            fails++; $display("FAIL reset_no_word: got valid=%b exp 0000", bus.out_valid);
        end
        for (int s = 0; s < 4; s++) begin
            bus.in_sel = 2'(s);
            #1;
            tests++;
            if (bus.in_ready !== 1'b1) begin
                fails++; $display("FAIL post_reset_ready sel=%0d: got %b exp 1", s, bus.in_ready);
            end
        end
    endtask

    task automatic test_steering;
        logic [WIDTH-1:0] exp_d [4];
        exp_d[0] = 64'hA0; exp_d[1] = 64'hB1; exp_d[2] = 64'hC2; exp_d[3] = 64'hD3;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            drive(1'b1, 2'(s), exp_d[s], 4'b0000);
            #1;
            tests++;
            if (bus.in_ready !== 1'b1) begin
                fails++; $display("FAIL steer_ready sel=%0d: got %b exp 1", s, bus.in_ready);
            end
        end
        @(negedge clk);
        drive(1'b0, 2'd0, '0, 4'b0000);
        #1;
        tests++;
        if (bus.out_valid !== 4'b1111 || bus.lane_full !== 4'b0000) begin
            fails++; $display("FAIL steer_flags: got valid=%b full=%b exp 1111/0000",
                              bus.out_valid, bus.lane_full);
        end
        for (int s = 0; s < 4; s++) begin
            tests++;
            if (bus.out_data[s] !== exp_d[s]) begin
                fails++; $display("FAIL steer_data lane=%0d: got %h exp %h", s, bus.out_data[s], exp_d[s]);
            end
        end
        bus.out_ready = 4'b1111;
        @(negedge clk);
        bus.out_ready = 4'b0000;
        #1;
        tests++;
        if (bus.out_valid !== 4'b0000) begin
            fails++; $display("FAIL steer_drain: got valid=%b exp 0000", bus.out_valid);
        end
    endtask

    task automatic test_full_blocking;
        @(negedge clk); drive(1'b1, 2'd2, 64'h11, 4'b0000);
        @(negedge clk); drive(1'b1, 2'd2, 64'h22, 4'b0000);
        @(negedge clk); drive(1'b1, 2'd2, 64'h33, 4'b0000);
        #1;
        tests++;
        if (bus.lane_full !== 4'b0100) begin
            fails++; $display("FAIL full_flag: got %b exp 0100", bus.lane_full);
        end
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL full_refuse: got in_ready=%b exp 0", bus.in_ready);
        end
        bus.in_sel  = 2'd0;
        bus.in_data = 64'h44;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL other_lane_ready: got %b exp 1", bus.in_ready);
        end
        @(negedge clk);
        drive(1'b0, 2'd0, '0, 4'b0100);
        #1;
        tests++;
        if (bus.out_data[2] !== 64'h11 || bus.lane_full[2] !== 1'b1) begin
            fails++; $display("FAIL full_head: got %h full=%b exp 11/1", bus.out_data[2], bus.lane_full[2]);
        end
        tests++;
        if (bus.out_valid[0] !== 1'b1 || bus.out_data[0] !== 64'h44) begin
            fails++; $display("FAIL lane0_word: got v=%b %h exp 1/44", bus.out_valid[0], bus.out_data[0]);
        end
        @(negedge clk); #1;
        tests++;
        if (bus.out_valid[2] !== 1'b1 || bus.out_data[2] !== 64'h22 || bus.lane_full[2] !== 1'b0) begin
            fails++; $display("FAIL full_second: got v=%b %h full=%b exp 1/22/0",
                              bus.out_valid[2], bus.out_data[2], bus.lane_full[2]);
        end
        @(negedge clk);
        bus.out_ready = 4'b0001;
        #1;
        tests++;
        if (bus.out_valid[2] !== 1'b0) begin
            fails++; $display("FAIL full_drained: got %b exp 0", bus.out_valid[2]);
        end
        @(negedge clk);
        bus.out_ready = 4'b0000;
        #1;
        tests++;
        if (bus.out_valid !== 4'b0000) begin
            fails++; $display("FAIL full_empty_all: got %b exp 0000", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] exp_head;
        @(negedge clk); drive(1'b1, 2'd1, 64'h55, 4'b0000);
        @(negedge clk); drive(1'b1, 2'd1, 64'h66, 4'b0010);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_data[1] !== 64'h55) begin
            fails++; $display("FAIL simul_pre: got rdy=%b %h exp 1/55", bus.in_ready, bus.out_data[1]);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.in_data = 64'h70 + 64'(i);
            #1;
            exp_head = (i == 0) ? 64'h66 : 64'h70 + 64'(i - 1);
            tests++;
            if (bus.in_ready !== 1'b1 || bus.out_valid[1] !== 1'b1 || bus.lane_full[1] !== 1'b0 ||
                bus.out_data[1] !== exp_head) begin
                fails++; $display("FAIL stream_%0d: got rdy=%b v=%b full=%b %h exp 1/1/0/%h",
                                  i, bus.in_ready, bus.out_valid[1], bus.lane_full[1],
                                  bus.out_data[1], exp_head);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        tests++;
        if (bus.out_valid[1] !== 1'b1 || bus.out_data[1] !== 64'h7F) begin
            fails++; $display("FAIL stream_last: got v=%b %h exp 1/7f", bus.out_valid[1], bus.out_data[1]);
        end
        @(negedge clk);
        bus.out_ready = 4'b0000;
        #1;
        tests++;
        if (bus.out_valid !== 4'b0000) begin
            fails++; $display("FAIL stream_empty: got %b exp 0000", bus.out_valid);
        end
    endtask

    task automatic test_mid_reset;
        @(negedge clk); drive(1'b1, 2'd3, 64'h99, 4'b0000);
        @(negedge clk); drive(1'b1, 2'd3, 64'hAA, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 2'd3, 64'hEE, 4'b1000);
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL mid_reset_ready: got %b exp 0", bus.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2'd3, 64'hBB, 4'b0000);
        #1;
        tests++;
        if (bus.out_valid !== 4'b0000 || bus.lane_full !== 4'b0000 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL mid_reset_clear: got v=%b full=%b rdy=%b exp 0000/0000/1",
                              bus.out_valid, bus.lane_full, bus.in_ready);
        end
        @(negedge clk);
        drive(1'b0, 2'd0, '0, 4'b1000);
        #1;
        tests++;
        if (bus.out_valid !== 4'b1000 || bus.out_data[3] !== 64'hBB) begin
            fails++; $display("FAIL mid_reset_first: got v=%b %h exp 1000/bb", bus.out_valid, bus.out_data[3]);
        end
        @(negedge clk);
        bus.out_ready = 4'b0000;
        #1;
        tests++;
        if (bus.out_valid !== 4'b0000) begin
            fails++; $display("FAIL mid_reset_stale: got %b exp 0000", bus.out_valid);
        end
    endtask

    task automatic test_soak;
        logic [WIDTH-1:0] q [4][$];
        logic             exp_rdy;
        int               sz;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)));
            #1;
            exp_rdy = (q[bus.in_sel].size() < 2);
            tests++;
            if (bus.in_ready !== exp_rdy) begin
                fails++; $display("FAIL soak_ready c=%0d: got %b exp %b", c, bus.in_ready, exp_rdy);
            end
            for (int k = 0; k < 4; k++) begin
                sz = q[k].size();
                tests++;
                if (bus.out_valid[k] !== (sz != 0) || bus.lane_full[k] !== (sz == 2) ||
                    (sz != 0 && bus.out_data[k] !== q[k][0])) begin
                    fails++; $display("FAIL soak_lane c=%0d k=%0d: got v=%b f=%b %h exp size %0d head %h",
                                      c, k, bus.out_valid[k], bus.lane_full[k], bus.out_data[k],
                                      sz, (sz != 0) ? q[k][0] : '0);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (bus.out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
            end
            if (bus.in_valid && exp_rdy) q[bus.in_sel].push_back(bus.in_data);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_steering();
        test_full_blocking();
        test_back_to_back();
        test_mid_reset();
        test_soak();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demux1_4_buf.md
# demux1_4_buf

Buffered 1-to-4 stream demultiplexer: the write/distribute counterpart to the 4:1 select path in the datapath. A single producer presents a WIDTH-bit word with a 2-bit lane select under a valid/ready handshake. The block steers the word into one of four independent 2-entry FIFO lanes. Each lane drains to its own consumer under its own valid/ready handshake. It sits between a shared result source and four destination units, for example write-back ports, so that one stalled consumer blocks only traffic addressed to it.

## Interface
- WIDTH, default 64: data width of every word.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- in_data  input  WIDTH  word offered by producer.
- in_sel  input  2  destination lane (0..3) of in_data.
- in_valid  input  1  producer offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts the offer this cycle.
- out_data  output  4×WIDTH  out_data[k] = head word of lane k.
- out_valid  output  4  out_valid[k] = lane k non-empty.
- out_ready  input  4  consumer k takes head of lane k this cycle.
- lane_full  output  4  lane k holds 2 words.

## Operation
- Four lanes, each a 2-entry FIFO: 1-bit read pointer, 1-bit write pointer, 2-bit count (0..2).
- Push: the push fires when in_valid & in_ready. The word is written to lane in_sel at its write pointer. The write pointer toggles and count increments.
- Pop on lane k: the pop fires when out_valid[k] & out_ready[k]. The read pointer toggles and count decrements.
- Pointer wrap-around: the 1-bit pointers wrap 1 -> 0 naturally.
- Simultaneous push and pop on the same lane: count is unchanged. Both pointers advance. The FIFO order of the words is preserved.
- in_ready = ~reset & ~lane_full[in_sel].
  - in_ready depends combinationally on in_sel and registered count only.
  - There is no path from out_ready to in_ready: a full lane refuses a push even if it pops in that cycle.
- in_ready is computed for the presented in_sel. A producer must not change in_sel while in_valid=1 and in_ready=0.
- Lanes are independent: a full lane k never affects in_ready for a push to any other lane.
- out_valid[k] = (count_k != 0); lane_full[k] = (count_k == 2). Both are decoded from registered count only.
- out_data[k] is the entry at the read pointer of lane k.
  - It is valid only when out_valid[k]=1.
  - When lane k is empty, out_data[k] holds the last-read storage contents, with no requirement on the value.
- Ordering: words addressed to the same lane exit in acceptance order. There is no ordering relation across lanes.
- Pops with out_valid[k]=0 are ignored: count never underflows.
- Reset, including mid-operation:
  - all counts and pointers = 0, so out_valid = 4'b0000 and lane_full = 4'b0000;
  - storage entries = 0, so out_data = all zeros;
  - in_ready = 0 while reset is high;
  - in-flight words are discarded and no push or pop occurs in the reset cycle.

## Timing
- A word pushed at rising edge N is visible with out_valid[k]=1 in the cycle after edge N. Minimum latency is 1 cycle, with no combinational in->out bypass.
- A word popped at edge M:
  - the next lane entry, if any, is presented in the cycle after M;
  - otherwise out_valid[k] falls after M.
- Throughput: 1 word/cycle per lane when the consumer holds out_ready[k]=1 continuously. Occupancy then alternates around 1 entry and never reaches full.
- Aggregate input throughput: 1 word/cycle.
- First cycle after reset deasserts: in_ready = 1 for every in_sel.

## Test plan
- Reset: hold reset=1 for 2 cycles with in_valid=1 and out_ready=4'b1111.
  - Required: in_ready=0, out_valid=4'b0000, lane_full=4'b0000, out_data all 0 throughout.
  - Required: no word appears after release.
- Steering: with out_ready=0, push 0xA0 to lane 0, 0xB1 to lane 1, 0xC2 to lane 2, 0xD3 to lane 3 on consecutive cycles.
  - Required: out_valid=4'b1111 and out_data = {0xD3, 0xC2, 0xB1, 0xA0}.
  - Required: lane_full=4'b0000.
- Full and blocking: with out_ready=0, push 0x11 then 0x22 to lane 2.
  - Required: lane_full[2]=1.
  - Required: an offer of 0x33 to lane 2 sees in_ready=0 and is not stored.
  - Required: a same-cycle offer of 0x44 to lane 0 sees in_ready=1.
  - Then set out_ready[2]=1 for 2 cycles. Required: 0x11 then 0x22 are popped, after which out_valid[2]=0.
- Simultaneous push and pop: lane 1 holds 0x55 and out_ready[1]=1; push 0x66 to lane 1 in the same cycle.
  - Required: count stays 1 and out_data[1]=0x66 next cycle.
  - Then stream 0x70..0x7F to lane 1 with out_ready[1]=1. Required: in-order delivery at 1 word/cycle with in_ready constantly 1.
- Mid-operation reset: fill lane 3 with 0x99 and 0xAA. Assert reset for 1 cycle while out_ready[3]=1 and in_valid=1.
  - Required: after reset, out_valid[3]=0 and lane_full[3]=0.
  - Required: neither old word appears.
  - Required: the next push, 0xBB, emerges first on lane 3.
- Randomized soak: 2000 cycles of random in_valid, in_sel, and out_ready against a per-lane reference queue.
  - Required: zero mismatches.
  - Required: no push is accepted when lane_full[in_sel]=1, and no pop occurs when out_valid=0.
